// File: rtl/quadra_sink.sv
// Result sink for the 3-cycle quadra pipeline: issues samples against a credit budget
// so every in-flight result is guaranteed a FIFO slot, and buffers results in order.
module quadra_sink #(
   parameter int Y_W   = 32,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       src_vld,
   output logic                       src_rdy,
   output logic                       x_dv,
   input  logic [Y_W-1:0]             y,
   input  logic                       y_dv,
   output logic [Y_W-1:0]             m_data,
   output logic                       m_vld,
   input  logic                       m_rdy,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH+1)-1:0] inflight,
   output logic                       ovf,
   output logic                       unexp
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
   localparam logic [CW:0]   CRED_LIM  = (CW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [Y_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [CW-1:0]  inflight_q, inflight_d;
   logic           ovf_q, ovf_d;
   logic           unexp_q, unexp_d;

   logic           credit_s;
   logic           issue_s;
   logic           pop_s;
   logic           push_s;
   logic           stray_s;

   // Credit accounting counts both stored and in-flight results, so a result that was
   // issued through this block can never find the FIFO full.
   always_comb begin
      credit_s = ({1'b0, count_q} + {1'b0, inflight_q}) < CRED_LIM;
      src_rdy  = credit_s & ~rst;
      issue_s  = src_vld & src_rdy;
      x_dv     = issue_s;
      pop_s    = (count_q != CNT_ZERO) & m_rdy;
      push_s   = y_dv & ((count_q != CNT_FULL) | pop_s);
      stray_s  = y_dv & (inflight_q == CNT_ZERO);
   end

   always_comb begin
      count_d    = count_q;
      inflight_d = inflight_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A result with nothing outstanding cannot retire an issue; it must not underflow.
      if (stray_s) begin
         inflight_d = issue_s ? (inflight_q + CNT_ONE) : inflight_q;
      end else begin
         case ({issue_s, y_dv})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
         endcase
      end

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      ovf_d   = ovf_q | (y_dv & ~push_s);
      unexp_d = unexp_q | stray_s;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         count_q    <= CNT_ZERO;
         inflight_q <= CNT_ZERO;
         ovf_q      <= 1'b0;
         unexp_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         ovf_q      <= ovf_d;
         unexp_q    <= unexp_d;
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         mem_q[wr_ptr_q] <= y;
      end
   end

   assign m_data   = mem_q[rd_ptr_q];
   assign m_vld    = (count_q != CNT_ZERO);
   assign count    = count_q;
   assign inflight = inflight_q;
   assign ovf      = ovf_q;
   assign unexp    = unexp_q;

endmodule

// File: doc/quadra_sink.md
QUADRA_SINK -- requirements
Module: quadra_sink

Interface
REQ-001 Parameter Y_W, default 32: result data width in bits, matching the quadra pipeline output y.
REQ-002 Parameter DEPTH, default 8: result FIFO depth in entries; power of two, at least 4.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  in  1: reset, synchronous and active-high.
REQ-005 Port src_vld  in  1: upstream requests to issue one sample into the quadra pipeline this cycle.
REQ-006 Port src_rdy  out  1: a credit is available for an issue this cycle.
REQ-007 Port x_dv  out  1: gated issue strobe to the pipeline's x_dv input; equals src_vld AND src_rdy.
REQ-008 Port y  in  Y_W: result data from the pipeline.
REQ-009 Port y_dv  in  1: result valid from the pipeline, arriving exactly 3 cycles after the matching x_dv.
REQ-010 Port m_data  out  Y_W: FIFO head data.
REQ-011 Port m_vld  out  1: FIFO head valid.
REQ-012 Port m_rdy  in  1: downstream accepts the head.
REQ-013 Port count  out  $clog2(DEPTH+1): FIFO occupancy.
REQ-014 Port inflight  out  $clog2(DEPTH+1): samples issued whose results have not yet arrived.
REQ-015 Port ovf  out  1: sticky flag; a result was dropped because the FIFO was full.
REQ-016 Port unexp  out  1: sticky flag; y_dv arrived while inflight was 0.

Function
REQ-017 The block SHALL drive src_rdy = 1 exactly when count + inflight < DEPTH, computed combinationally from registered state.
REQ-018 An issue SHALL be counted only when x_dv = 1.
REQ-019 The block SHALL assert m_vld = (count != 0), with m_data presenting the oldest stored entry; the FIFO order SHALL be first in, first out.
REQ-020 A push SHALL occur when y_dv = 1 and either count < DEPTH or a pop occurs in the same cycle.
REQ-021 A pop SHALL occur when m_vld = 1 and m_rdy = 1.
REQ-022 A push SHALL update m_vld and m_data no earlier than the next cycle; there SHALL be no combinational bypass from y to m_data.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and SHALL be accepted at every occupancy, including full and empty-with-entry.
REQ-024 On y_dv with count = DEPTH and no pop in the same cycle, the block SHALL discard the data, leave count unchanged and set ovf.
REQ-025 Inflight SHALL increment on x_dv, decrement on y_dv, and stay unchanged when both occur in the same cycle.
REQ-026 On y_dv with inflight = 0, the block SHALL set unexp, hold inflight at 0 and still push the data under REQ-020.
REQ-027 The write and read pointers SHALL wrap modulo DEPTH.
REQ-028 Flags ovf and unexp SHALL clear only on reset.
REQ-029 While m_vld = 1 and m_rdy = 0, the block SHALL hold m_data stable.

Reset
REQ-030 While rst = 1, the block SHALL clear count, inflight, both pointers, ovf and unexp to 0 in the same clock edge.
REQ-031 While rst = 1, m_vld SHALL be 0 from the first edge with rst high, and src_rdy and x_dv SHALL be 0.
REQ-032 A reset asserted mid-operation SHALL discard stored entries; y_dv pulses for pre-reset issues that arrive after reset SHALL follow REQ-026.
REQ-033 The block SHALL leave m_data unspecified during reset.

Verification
REQ-034 Streaming: DEPTH=8, src_vld=1 and m_rdy=1 for 20 cycles, y=x*x model -> 20 results delivered in order; count stays at or below 1; inflight stays at or below 3; ovf=0 and unexp=0.
REQ-035 Backpressure: m_rdy=0, src_vld=1 -> exactly 8 issues accepted; src_rdy drops after the 8th issue; count reaches 8 with inflight=0; ovf=0.
REQ-036 Full plus drain: count=8, pulse m_rdy for 1 cycle -> exactly one pop; src_rdy=1 for one credit; the next issue's result lands 3 cycles later with count=8.
REQ-037 Forced overflow: count=8, inject y_dv=1 with y=0xDEADBEEF and m_rdy=0 -> count stays 8; ovf=1 sticky; 0xDEADBEEF never appears on m_data.
REQ-038 Spurious result: after reset, inject y_dv=1 with y=5 -> unexp=1; inflight=0; m_data=5 with m_vld=1 on the next cycle.
REQ-039 Mid-operation reset: rst=1 for 1 cycle with count=5 and inflight=2 -> the next cycle shows count=0, inflight=0 and m_vld=0; the 2 late y_dv pulses set unexp.
